tmds_period_sequencer: RTL and testbench

- Sequences HDMI video-period framing for the three TMDS encoders, which are clocked by pixclk.
- Takes raw timing (hsync, vsync, blank) and pixel data from the VGA controller, delays it by a fixed lookahead, and inserts the 8-cycle video preamble and the 2-cycle leading guard band before every active-video run.
- Drives per-channel encoder mode and the CTL control bits.
- With enable low it degrades to plain DVI framing at the same latency.

---
 rtl/tmds_period_sequencer.sv | 131 +++++++++++++
 tb/tb_tmds_period_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/tmds_period_sequencer.sv
// HDMI video-period framing for the TMDS encoders: delays raw timing and pixels by a fixed
// lookahead and inserts the video preamble and leading guard band before each active run.
module tmds_period_sequencer #(
    parameter int PRE_LEN  = 8,
    parameter int GB_LEN   = 2,
    parameter int MIN_CTRL = 4,
    parameter int DATA_W   = 24
) (
    input  logic              pixclk,
    input  logic              reset,
    input  logic              enable,
    input  logic              hsync_i,
    input  logic              vsync_i,
    input  logic              blank_i,
    input  logic [DATA_W-1:0] pixel_i,
    output logic              hsync_o,
    output logic              vsync_o,
    output logic              de_o,
    output logic [DATA_W-1:0] pixel_o,
    output logic [1:0]        mode_o,
    output logic [3:0]        ctl_o,
    output logic              short_ctrl_err
);

    localparam int LEAD = PRE_LEN + GB_LEN + 1;
    localparam logic [3:0] PRE_LAST = 4'(PRE_LEN - 1);
    localparam logic [3:0] GB_LAST  = 4'(GB_LEN - 1);
    localparam logic [3:0] MIN_CNT  = 4'(MIN_CTRL);

    typedef enum logic [1:0] {
        ST_CTRL     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_GUARD    = 2'd2,
        ST_VIDEO    = 2'd3
    } state_e;

    typedef struct packed {
        logic              hsync;
        logic              vsync;
        logic              de;
        logic [DATA_W-1:0] pixel;
    } tap_t;

    tap_t   line_q [LEAD];
    state_e state_q;
    logic [3:0] phase_q;
    logic [3:0] ctrl_cnt_q;
    logic [3:0] ctrl_cnt_d;
    logic       blank_q;
    logic       err_q;
    logic [3:0] ctl_q;
    logic       rise;
    logic       de_next;
    logic       start_pre;
    logic       skip;

    // NOTE: the delay line is reset like any other state so outputs read zero until fresh input arrives.
    always_ff @(posedge pixclk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LEAD; i++) line_q[i] <= '0;
        end else begin
            line_q[0] <= '{hsync: hsync_i, vsync: vsync_i, de: blank_i, pixel: pixel_i};
            for (int i = 1; i < LEAD; i++) line_q[i] <= line_q[i-1];
        end
    end

    // ctrl_cnt_d counts control cycles up to and including the current output cycle.
    always_comb begin
        ctrl_cnt_d = 4'd0;
        if (state_q == ST_CTRL) ctrl_cnt_d = (ctrl_cnt_q == 4'hF) ? 4'hF : ctrl_cnt_q + 4'd1;
    end

    assign rise      = blank_i & ~blank_q;
    assign de_next   = line_q[LEAD-2].de;
    assign start_pre = enable & rise & (state_q == ST_CTRL) & (ctrl_cnt_d >= MIN_CNT);
    assign skip      = enable & rise & ~start_pre;

    always_ff @(posedge pixclk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_CTRL;
            phase_q    <= 4'd0;
            ctrl_cnt_q <= 4'd0;
            blank_q    <= 1'b0;
            err_q      <= 1'b0;
            ctl_q      <= 4'd0;
        end else begin
            blank_q    <= blank_i;
            ctrl_cnt_q <= ctrl_cnt_d;
            err_q      <= skip;
            ctl_q      <= 4'd0;
            case (state_q)
                ST_PREAMBLE: begin
                    if (phase_q == PRE_LAST) begin
                        state_q <= ST_GUARD;
                        phase_q <= 4'd0;
                    end else begin
                        phase_q <= phase_q + 4'd1;
                        ctl_q   <= 4'b0001;
                    end
                end
                ST_GUARD: begin
                    if (phase_q == GB_LAST) begin
                        state_q <= ST_VIDEO;
                        phase_q <= 4'd0;
                    end else begin
                        phase_q <= phase_q + 4'd1;
                    end
                end
                default: begin
                    // Outside a framed sequence the mode simply follows the delayed data enable.
                    if (start_pre) begin
                        state_q <= ST_PREAMBLE;
                        phase_q <= 4'd0;
                        ctl_q   <= 4'b0001;
                    end else begin
                        state_q <= de_next ? ST_VIDEO : ST_CTRL;
                    end
                end
            endcase
        end
    end

    assign hsync_o        = line_q[LEAD-1].hsync;
    assign vsync_o        = line_q[LEAD-1].vsync;
    assign de_o           = line_q[LEAD-1].de;
    assign pixel_o        = line_q[LEAD-1].pixel;
    assign mode_o         = state_q;
    assign ctl_o          = ctl_q;
    assign short_ctrl_err = err_q;

endmodule

// File: tb/tb_tmds_period_sequencer.sv
// Self-checking bench: default and reduced-lookahead instances against a history/schedule model.
module tb_tmds_period_sequencer;

    localparam int DW   = 24;
    localparam int HMAX = 16384;
    localparam int MINC = 4;

    logic          pixclk = 1'b0;
    logic          reset  = 1'b1;
    logic          enable = 1'b1;
    logic          hsync_i = 1'b0, vsync_i = 1'b0, blank_i = 1'b0;
    logic [DW-1:0] pixel_i = '0;

    logic          a_hs, a_vs, a_de, a_err, b_hs, b_vs, b_de, b_err;
    logic [DW-1:0] a_pix, b_pix;
    logic [1:0]    a_mode, b_mode;
    logic [3:0]    a_ctl, b_ctl;

    always #5 pixclk = ~pixclk;

    tmds_period_sequencer #(.PRE_LEN(8), .GB_LEN(2), .MIN_CTRL(MINC), .DATA_W(DW)) dut_a (
        .pixclk(pixclk), .reset(reset), .enable(enable),
        .hsync_i(hsync_i), .vsync_i(vsync_i), .blank_i(blank_i), .pixel_i(pixel_i),
        .hsync_o(a_hs), .vsync_o(a_vs), .de_o(a_de), .pixel_o(a_pix),
        .mode_o(a_mode), .ctl_o(a_ctl), .short_ctrl_err(a_err));

    tmds_period_sequencer #(.PRE_LEN(4), .GB_LEN(1), .MIN_CTRL(MINC), .DATA_W(DW)) dut_b (
        .pixclk(pixclk), .reset(reset), .enable(enable),
        .hsync_i(hsync_i), .vsync_i(vsync_i), .blank_i(blank_i), .pixel_i(pixel_i),
        .hsync_o(b_hs), .vsync_o(b_vs), .de_o(b_de), .pixel_o(b_pix),
        .mode_o(b_mode), .ctl_o(b_ctl), .short_ctrl_err(b_err));

    int n_checks = 0;
    int n_fail   = 0;
    int n        = 0;
    int base     = 0;

    bit            blank_h [HMAX];
    bit            hs_h    [HMAX];
    bit            vs_h    [HMAX];
    bit            en_h    [HMAX];
    logic [DW-1:0] pix_h   [HMAX];
    int            mode_h  [2][HMAX];
    int            fmode   [2][HMAX];
    bit            err_s   [2][HMAX];

    function automatic int pre_of(input int k);
        return (k == 0) ? 8 : 4;
    endfunction

    function automatic int gb_of(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, n, got, exp);
        end
    endtask

    task automatic check_zero();
        check("rst_mode_a", 32'(a_mode), 32'd0);
        check("rst_ctl_a",  32'(a_ctl),  32'd0);
        check("rst_err_a",  32'(a_err),  32'd0);
        check("rst_de_a",   32'(a_de),   32'd0);
        check("rst_sync_a", 32'({a_hs, a_vs}), 32'd0);
        check("rst_pix_a",  32'(a_pix),  32'd0);
        check("rst_mode_b", 32'(b_mode), 32'd0);
        check("rst_de_b",   32'(b_de),   32'd0);
        check("rst_pix_b",  32'(b_pix),  32'd0);
    endtask

    // Expected outputs: delayed inputs, scheduled preamble/guard windows, else mode follows de.
    task automatic model_check(input int k);
        int            src;
        bit            e_de, e_hs, e_vs;
        logic [DW-1:0] e_pix;
        int            e_mode;
        logic [1:0]    o_mode;
        logic [3:0]    o_ctl;
        logic          o_de, o_hs, o_vs, o_err;
        logic [DW-1:0] o_pix;
        src   = n - (pre_of(k) + gb_of(k) + 1);
        e_de  = (src >= base) ? blank_h[src] : 1'b0;
        e_hs  = (src >= base) ? hs_h[src]    : 1'b0;
        e_vs  = (src >= base) ? vs_h[src]    : 1'b0;
        e_pix = (src >= base) ? pix_h[src]   : '0;
        e_mode = (fmode[k][n] != 0) ? fmode[k][n] : (e_de ? 3 : 0);
        mode_h[k][n] = e_mode;
        if (k == 0) begin
            o_mode = a_mode; o_ctl = a_ctl; o_de = a_de; o_hs = a_hs; o_vs = a_vs; o_err = a_err; o_pix = a_pix;
        end else begin
            o_mode = b_mode; o_ctl = b_ctl; o_de = b_de; o_hs = b_hs; o_vs = b_vs; o_err = b_err; o_pix = b_pix;
        end
        check($sformatf("de_%0d", k),    32'(o_de),   32'(e_de));
        check($sformatf("hsync_%0d", k), 32'(o_hs),   32'(e_hs));
        check($sformatf("vsync_%0d", k), 32'(o_vs),   32'(e_vs));
        check($sformatf("pixel_%0d", k), 32'(o_pix),  32'(e_pix));
        check($sformatf("mode_%0d", k),  32'(o_mode), 32'(e_mode));
        check($sformatf("ctl_%0d", k),   32'(o_ctl),  (e_mode == 1) ? 32'd1 : 32'd0);
        check($sformatf("err_%0d", k),   32'(o_err),  32'(err_s[k][n]));
    endtask

    task automatic model_advance(input int k);
        bit prev;
        int cnt;
        prev = (n - 1 >= base) ? blank_h[n-1] : 1'b0;
        if (en_h[n] && blank_h[n] && !prev) begin
            cnt = 0;
            for (int j = n; j >= base && mode_h[k][j] == 0 && cnt < 15; j--) cnt++;
            if (cnt >= MINC) begin
                for (int j = 1; j <= pre_of(k); j++) fmode[k][n+j] = 1;
                for (int j = 1; j <= gb_of(k); j++) fmode[k][n+pre_of(k)+j] = 2;
            end else begin
                err_s[k][n+1] = 1'b1;
            end
        end
    endtask

    task automatic step(input bit b, input bit hs, input bit vs, input bit en);
        @(posedge pixclk);
        #1;
        if (reset) begin
            reset = 1'b0;
            base  = n;
            for (int k = 0; k < 2; k++)
                for (int j = n; j < n + 24; j++) begin
                    fmode[k][j] = 0;
                    err_s[k][j] = 1'b0;
                end
        end
        blank_i = b; hsync_i = hs; vsync_i = vs; enable = en;
        pixel_i = DW'($urandom());
        blank_h[n] = b; hs_h[n] = hs; vs_h[n] = vs; en_h[n] = en; pix_h[n] = pixel_i;
        @(negedge pixclk);
        for (int k = 0; k < 2; k++) model_check(k);
        for (int k = 0; k < 2; k++) model_advance(k);
        n++;
    endtask

    task automatic run(input int len, input bit b, input bit en);
        for (int i = 0; i < len; i++) step(b, 1'($urandom()), 1'($urandom()), en);
    endtask

    // Asserted just after a falling edge; released by the next step().
    task automatic do_reset();
        #1 reset = 1'b1;
        #1 check_zero();
        @(negedge pixclk);
    endtask

    initial begin
        repeat (3) @(negedge pixclk);
        check_zero();

        // Single framed run after a long control period.
        run(40, 1'b0, 1'b1);
        run(16, 1'b1, 1'b1);
        run(30, 1'b0, 1'b1);

        // Walking sync pattern, then inverted polarity.
        for (int i = 0; i < 36; i++)
            step(1'b0, 1'((i % 6 == 0) ^ (i >= 18)), 1'((i % 6 == 3) ^ (i >= 18)), 1'b1);

        // Short blanking gap forces the skip path on the second run.
        run(16, 1'b1, 1'b1);
        run(6,  1'b0, 1'b1);
        run(16, 1'b1, 1'b1);
        run(30, 1'b0, 1'b1);

        // DVI framing.
        run(40, 1'b0, 1'b0);
        run(16, 1'b1, 1'b0);
        run(30, 1'b0, 1'b0);

        // Reset in the middle of a preamble, then a clean framed run.
        run(20, 1'b0, 1'b1);
        run(5,  1'b1, 1'b1);
        do_reset();
        run(20, 1'b0, 1'b1);
        run(16, 1'b1, 1'b1);
        run(20, 1'b0, 1'b1);

        // Randomized runs and gaps, enable changes and occasional resets.
        for (int seg = 0; seg < 150; seg++) begin
            bit en;
            int gap, len;
            en  = ($urandom_range(0, 4) != 0);
            gap = $urandom_range(1, 20);
            len = $urandom_range(11, 40);
            run(gap, 1'b0, en);
            if ($urandom_range(0, 15) == 0) begin
                run($urandom_range(1, 6), 1'b1, en);
                do_reset();
            end
            run(len, 1'b1, en);
        end
        run(30, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
